lsu_queue: RTL and testbench
============================

# lsu_queue

Parametrised, in-order load/store queue that succeeds the single-entry-at-a-time memory queue and sits between rename/dispatch, the address generation unit (AGU), the ROB and the data cache. Entries are allocated at dispatch and receive address and store data from the AGU. Each head entry is issued to the dcache through a proper request/accept/response handshake. Stores are held until they reach the ROB head. Results return on a registered writeback port, and an optional flush clears the queue on mispredict.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2; IDX_W = $clog2(DEPTH)
- ROB_W, 5, ROB index width
- PREG_W, 6, physical register tag width
- AREG_W, 5, architectural register width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- enq_valid  in  1  dispatch allocates an entry
- enq_ready  out  1  entry free (count < DEPTH)
- enq_is_store  in  1  1 = store, 0 = load
- enq_funct3  in  3  RV32I load/store funct3
- enq_pd  in  PREG_W  destination physical register
- enq_rd  in  AREG_W  destination architectural register
- enq_rob  in  ROB_W  ROB index
- enq_idx  out  IDX_W  slot the next enqueue will occupy (= tail)
- agu_valid  in  1  AGU result valid
- agu_idx  in  IDX_W  target slot
- agu_addr  in  32  effective byte address
- agu_wdata  in  32  store source data (rs2)
- rob_head  in  ROB_W  ROB head index
- rob_head_valid  in  1  rob_head is meaningful
- d_req  out  1  dcache request
- d_ready  in  1  dcache accepts request this cycle
- d_addr  out  32  word-aligned address
- d_rmask  out  4  byte read mask
- d_wmask  out  4  byte write mask
- d_wdata  out  32  lane-aligned write data
- d_resp  in  1  dcache response (one cycle)
- d_rdata  in  32  read word
- wb_valid, wb_is_store  out  1 each  writeback pulse / kind
- wb_rob  out  ROB_W; wb_pd  out  PREG_W; wb_rd  out  AREG_W (0 for stores)
- wb_data  out  32  extended load result, 0 for stores
- count  out  IDX_W+1  occupied entries; empty  out  1

## Operation
- Circular buffer; head and tail pointers are IDX_W bits, plus count. Entry fields: valid, addr_rdy, is_store, funct3, pd, rd, rob, addr, wdata.
- Enqueue when enq_valid && enq_ready: write slot tail, addr_rdy=0, tail+1 (wraps DEPTH-1→0). enq_valid while !enq_ready is ignored.
- AGU write: sets addr/wdata/addr_rdy on slot agu_idx if that slot is valid. A write to an invalid slot is ignored.
- Head eligible: valid && addr_rdy && (!is_store || (rob_head_valid && rob_head == rob)).
- FSM IDLE→REQ when head eligible; in REQ, d_req=1 with stable fields; REQ→WAIT on d_ready; WAIT→IDLE on d_resp, which frees head (valid=0, head+1, count−1).
- Masks: byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'b1111; result truncated to 4 bits (misalignment unchecked). d_wdata: byte/half replicated into the addressed lane. Stores drive rmask=0; loads drive wmask=0.
- Load data: lb/lh sign-extend, lbu/lhu zero-extend the addressed lane; lw passes through. Reserved funct3 produces 0.
- Enqueue and dequeue in the same cycle: count unchanged.

## Timing
- Reset: all outputs 0 except enq_ready=1 and empty=1. Pointers and count are 0, all entries are invalid, and the FSM is IDLE.
- Eligible head → d_req next cycle (registered). Minimum issue-to-writeback is 3 cycles (REQ, WAIT, d_resp).
- wb_* is registered and pulses exactly one cycle, the cycle after d_resp.
- enq_ready and count reflect registered state; a same-cycle dequeue does not free a slot for that cycle's enqueue.
- Back-to-back: IDLE after d_resp re-evaluates the new head, giving a 1-cycle bubble per access.

## Configuration
- LSU_QUEUE_FLUSH_EN defined:
  - Input port flush (1 bit) exists.
  - Flush invalidates all entries and zeroes head, tail and count the next cycle. Enqueue and AGU writes in that cycle are ignored.
  - In REQ, the FSM returns to IDLE and d_req drops.
  - In WAIT, the FSM enters DRAIN. DRAIN absorbs the next d_resp without writeback, then returns to IDLE, and does not issue until then.
- Not defined: no flush port and no DRAIN state. The queue only empties by completion.

## Test plan
- Enqueue lw at rob 3; AGU addr 0x1004 → d_req, d_addr 0x1004, rmask 1111. d_resp with data 0xDEADBEEF → one wb pulse: data 0xDEADBEEF, rob 3, count 0.
- lb at 0x2003 with d_rdata 0x80FFFFFF → rmask 1000, wb_data 0xFFFFFF80. Same access as lbu → 0x00000080.
- sh at 0x3002 with wdata 0x1234 and rob_head≠rob → no d_req. Set rob_head=rob → wmask 1100, d_wdata[31:16]=0x1234, wb_is_store=1, wb_data 0.
- Fill DEPTH=8 entries → enq_ready 0, and a ninth enq_valid is ignored. Complete one entry, then the next enqueue lands at slot 0 (wrap) and count returns to 8.
- Hold d_ready=0 for 5 cycles → d_req and all d_* fields stay stable, and there is no writeback until d_ready and then d_resp arrive.
- With LSU_QUEUE_FLUSH_EN: flush in WAIT with 3 entries → count 0 next cycle; the following d_resp produces no wb_valid. A new enqueue takes slot 0.

Source files
------------

// File: rtl/lsu_queue_if.sv
// Data-cache request/response bus between lsu_queue (master) and the dcache (slave).
interface lsu_queue_if;
    logic        d_req;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        d_resp;
    logic [31:0] d_rdata;

    modport master (
        output d_req, d_addr, d_rmask, d_wmask, d_wdata,
        input  d_ready, d_resp, d_rdata
    );

    modport slave (
        input  d_req, d_addr, d_rmask, d_wmask, d_wdata,
        output d_ready, d_resp, d_rdata
    );
endinterface

// File: rtl/lsu_queue.sv
// In-order load/store queue issuing one head entry at a time to the dcache.
// Optional mispredict flush (and DRAIN state) enabled by defining LSU_QUEUE_FLUSH_EN.
module lsu_queue #(
    parameter int  DEPTH  = 8,
    parameter int  ROB_W  = 5,
    parameter int  PREG_W = 6,
    parameter int  AREG_W = 5,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef LSU_QUEUE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic              enq_is_store,
    input  logic [2:0]        enq_funct3,
    input  logic [PREG_W-1:0] enq_pd,
    input  logic [AREG_W-1:0] enq_rd,
    input  logic [ROB_W-1:0]  enq_rob,
    output logic [IDX_W-1:0]  enq_idx,
    input  logic              agu_valid,
    input  logic [IDX_W-1:0]  agu_idx,
    input  logic [31:0]       agu_addr,
    input  logic [31:0]       agu_wdata,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              rob_head_valid,
    lsu_queue_if.master       dbus,
    output logic              wb_valid,
    output logic              wb_is_store,
    output logic [ROB_W-1:0]  wb_rob,
    output logic [PREG_W-1:0] wb_pd,
    output logic [AREG_W-1:0] wb_rd,
    output logic [31:0]       wb_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2
`ifdef LSU_QUEUE_FLUSH_EN
        , ST_DRAIN = 2'd3
`endif
    } state_t;

    // Byte lanes touched by an access of size code sz at byte offset ofs (4-bit truncated).
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] ofs);
        case (sz)
            2'b00:   lane_mask = 4'b0001 << ofs;
            2'b01:   lane_mask = 4'b0011 << ofs;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   store_lanes = {4{wd[7:0]}};
            2'b01:   store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ofs,
                                             input logic [31:0] rdata);
        logic [15:0] lane;
        lane = 16'(rdata >> {ofs, 3'b000});
        case (f3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_ext = rdata;
            3'b100:  load_ext = {24'h00_0000, lane[7:0]};
            3'b101:  load_ext = {16'h0000, lane[15:0]};
            default: load_ext = 32'h0000_0000;
        endcase
    endfunction

    logic [DEPTH-1:0]  ent_valid_r;
    logic [DEPTH-1:0]  ent_addr_rdy_r;
    logic [DEPTH-1:0]  ent_is_store_r;
    logic [2:0]        ent_funct3_r [DEPTH];
    logic [PREG_W-1:0] ent_pd_r     [DEPTH];
    logic [AREG_W-1:0] ent_rd_r     [DEPTH];
    logic [ROB_W-1:0]  ent_rob_r    [DEPTH];
    logic [31:0]       ent_addr_r   [DEPTH];
    logic [31:0]       ent_wdata_r  [DEPTH];

    logic [IDX_W-1:0]  head_r, tail_r;
    logic [CNT_W-1:0]  count_r, count_nx_s;
    logic              enq_ready_r, empty_r;
    state_t            state_r, state_nx_s;
    logic              d_req_r;
    logic [31:0]       d_addr_r, d_wdata_r;
    logic [3:0]        d_rmask_r, d_wmask_r;
    logic              wb_valid_r, wb_is_store_r;
    logic [ROB_W-1:0]  wb_rob_r;
    logic [PREG_W-1:0] wb_pd_r;
    logic [AREG_W-1:0] wb_rd_r;
    logic [31:0]       wb_data_r;

    logic flush_s, head_elig_s, enq_fire_s, deq_s;

`ifdef LSU_QUEUE_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign head_elig_s = ent_valid_r[head_r] && ent_addr_rdy_r[head_r] &&
                         (!ent_is_store_r[head_r] ||
                          (rob_head_valid && (rob_head == ent_rob_r[head_r])));
    assign enq_fire_s  = enq_valid && enq_ready_r && !flush_s;

    // Issue FSM next state; deq_s marks a completing access that retires the head.
    always_comb begin
        state_nx_s = state_r;
        deq_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!flush_s && head_elig_s) state_nx_s = ST_REQ;
                else                         state_nx_s = ST_IDLE;
            end
            ST_REQ: begin
                if (flush_s)           state_nx_s = ST_IDLE;
                else if (dbus.d_ready) state_nx_s = ST_WAIT;
                else                   state_nx_s = ST_REQ;
            end
            ST_WAIT: begin
                // A response coinciding with flush is simply dropped: nothing left to drain.
                if (dbus.d_resp) begin
                    state_nx_s = ST_IDLE;
                    deq_s      = !flush_s;
                end else begin
`ifdef LSU_QUEUE_FLUSH_EN
                    if (flush_s) state_nx_s = ST_DRAIN;
                    else         state_nx_s = ST_WAIT;
`else
                    state_nx_s = ST_WAIT;
`endif
                end
            end
`ifdef LSU_QUEUE_FLUSH_EN
            ST_DRAIN: begin
                if (dbus.d_resp) state_nx_s = ST_IDLE;
                else             state_nx_s = ST_DRAIN;
            end
`endif
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Occupancy for the next cycle.
    always_comb begin
        count_nx_s = count_r;
        if (flush_s)                  count_nx_s = {CNT_W{1'b0}};
        else if (enq_fire_s && !deq_s) count_nx_s = count_r + CNT_W'(1);
        else if (!enq_fire_s && deq_s) count_nx_s = count_r - CNT_W'(1);
        else                          count_nx_s = count_r;
    end

    // Queue storage, pointers and occupancy flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid_r    <= {DEPTH{1'b0}};
            ent_addr_rdy_r <= {DEPTH{1'b0}};
            ent_is_store_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_funct3_r[i] <= 3'b000;
                ent_pd_r[i]     <= {PREG_W{1'b0}};
                ent_rd_r[i]     <= {AREG_W{1'b0}};
                ent_rob_r[i]    <= {ROB_W{1'b0}};
                ent_addr_r[i]   <= 32'h0000_0000;
                ent_wdata_r[i]  <= 32'h0000_0000;
            end
            head_r      <= {IDX_W{1'b0}};
            tail_r      <= {IDX_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            enq_ready_r <= 1'b1;
            empty_r     <= 1'b1;
        end else begin
            count_r     <= count_nx_s;
            enq_ready_r <= (count_nx_s != CNT_W'(DEPTH));
            empty_r     <= (count_nx_s == {CNT_W{1'b0}});
            if (flush_s) begin
                ent_valid_r <= {DEPTH{1'b0}};
                head_r      <= {IDX_W{1'b0}};
                tail_r      <= {IDX_W{1'b0}};
            end else begin
                if (enq_fire_s) begin
                    ent_valid_r[tail_r]    <= 1'b1;
                    ent_addr_rdy_r[tail_r] <= 1'b0;
                    ent_is_store_r[tail_r] <= enq_is_store;
                    ent_funct3_r[tail_r]   <= enq_funct3;
                    ent_pd_r[tail_r]       <= enq_pd;
                    ent_rd_r[tail_r]       <= enq_rd;
                    ent_rob_r[tail_r]      <= enq_rob;
                    tail_r                 <= tail_r + IDX_W'(1);
                end
                if (agu_valid && ent_valid_r[agu_idx]) begin
                    ent_addr_rdy_r[agu_idx] <= 1'b1;
                    ent_addr_r[agu_idx]     <= agu_addr;
                    ent_wdata_r[agu_idx]    <= agu_wdata;
                end
                if (deq_s) begin
                    ent_valid_r[head_r] <= 1'b0;
                    head_r              <= head_r + IDX_W'(1);
                end
            end
        end
    end

    // FSM state and registered dcache request, captured once when the head is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            d_req_r   <= 1'b0;
            d_addr_r  <= 32'h0000_0000;
            d_rmask_r <= 4'b0000;
            d_wmask_r <= 4'b0000;
            d_wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nx_s;
            d_req_r <= (state_nx_s == ST_REQ);
            if ((state_r == ST_IDLE) && (state_nx_s == ST_REQ)) begin
                d_addr_r <= {ent_addr_r[head_r][31:2], 2'b00};
                if (ent_is_store_r[head_r]) begin
                    d_rmask_r <= 4'b0000;
                    d_wmask_r <= lane_mask(ent_funct3_r[head_r][1:0], ent_addr_r[head_r][1:0]);
                    d_wdata_r <= store_lanes(ent_funct3_r[head_r][1:0], ent_wdata_r[head_r]);
                end else begin
                    d_rmask_r <= lane_mask(ent_funct3_r[head_r][1:0], ent_addr_r[head_r][1:0]);
                    d_wmask_r <= 4'b0000;
                    d_wdata_r <= 32'h0000_0000;
                end
            end
        end
    end

    // Writeback: one-cycle pulse after the completing response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_r    <= 1'b0;
            wb_is_store_r <= 1'b0;
            wb_rob_r      <= {ROB_W{1'b0}};
            wb_pd_r       <= {PREG_W{1'b0}};
            wb_rd_r       <= {AREG_W{1'b0}};
            wb_data_r     <= 32'h0000_0000;
        end else begin
            wb_valid_r <= deq_s;
            if (deq_s) begin
                wb_is_store_r <= ent_is_store_r[head_r];
                wb_rob_r      <= ent_rob_r[head_r];
                wb_pd_r       <= ent_pd_r[head_r];
                if (ent_is_store_r[head_r]) begin
                    wb_rd_r   <= {AREG_W{1'b0}};
                    wb_data_r <= 32'h0000_0000;
                end else begin
                    wb_rd_r   <= ent_rd_r[head_r];
                    wb_data_r <= load_ext(ent_funct3_r[head_r], ent_addr_r[head_r][1:0],
                                          dbus.d_rdata);
                end
            end
        end
    end

    assign enq_ready    = enq_ready_r;
    assign enq_idx      = tail_r;
    assign count        = count_r;
    assign empty        = empty_r;
    assign dbus.d_req   = d_req_r;
    assign dbus.d_addr  = d_addr_r;
    assign dbus.d_rmask = d_rmask_r;
    assign dbus.d_wmask = d_wmask_r;
    assign dbus.d_wdata = d_wdata_r;
    assign wb_valid     = wb_valid_r;
    assign wb_is_store  = wb_is_store_r;
    assign wb_rob       = wb_rob_r;
    assign wb_pd        = wb_pd_r;
    assign wb_rd        = wb_rd_r;
    assign wb_data      = wb_data_r;

endmodule

// File: tb/tb_lsu_queue.sv
// Self-checking bench for lsu_queue: directed vector table, fill/wrap sequence,
// randomized accesses against a byte-level reference model, optional flush sequence.
module tb_lsu_queue;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enq_valid, enq_ready, enq_is_store;
    logic [2:0]  enq_funct3;
    logic [5:0]  enq_pd;
    logic [4:0]  enq_rd, enq_rob;
    logic [2:0]  enq_idx;
    logic        agu_valid;
    logic [2:0]  agu_idx;
    logic [31:0] agu_addr, agu_wdata;
    logic [4:0]  rob_head;
    logic        rob_head_valid;
    logic        wb_valid, wb_is_store;
    logic [4:0]  wb_rob, wb_rd;
    logic [5:0]  wb_pd;
    logic [31:0] wb_data;
    logic [3:0]  count;
    logic        empty;

    lsu_queue_if dbus();

    always #5 clk = ~clk;

    lsu_queue #(.DEPTH(DEPTH), .ROB_W(5), .PREG_W(6), .AREG_W(5)) dut (
        .clk(clk), .rst(rst),
`ifdef LSU_QUEUE_FLUSH_EN
        .flush(flush),
`endif
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
        .enq_funct3(enq_funct3), .enq_pd(enq_pd), .enq_rd(enq_rd), .enq_rob(enq_rob),
        .enq_idx(enq_idx), .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr),
        .agu_wdata(agu_wdata), .rob_head(rob_head), .rob_head_valid(rob_head_valid),
        .dbus(dbus), .wb_valid(wb_valid), .wb_is_store(wb_is_store), .wb_rob(wb_rob),
        .wb_pd(wb_pd), .wb_rd(wb_rd), .wb_data(wb_data), .count(count), .empty(empty)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [4:0]  rob;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  rmask, wmask;
        logic [31:0] wexp, dexp;
        logic        nomask;
        int          stall;
        int          block;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int mt       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                                input logic [31:0] addr, wdata, rdata, input logic [3:0] rm, wm,
                                input logic [31:0] wexp, dexp, input logic nomask,
                                input int stall, input int block);
        vec_t v;
        v.st = st; v.f3 = f3; v.rob = rob; v.pd = 6'(rob) + 6'd1; v.rd = rob ^ 5'h15;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rmask = rm; v.wmask = wm;
        v.wexp = wexp; v.dexp = dexp; v.nomask = nomask; v.stall = stall; v.block = block;
        return v;
    endfunction

    // Reference model: byte-level view of the access.
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] addr);
        int sz = size_of(f3);
        int ofs = int'(addr % 4);
        logic [3:0] m = 4'h0;
        if (sz == 4) return 4'hF;
        for (int b = 0; b < 4; b++) if (sz > 0 && b >= ofs && b < ofs + sz) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] wd);
        logic [3:0] m = ref_mask(f3, addr);
        int ofs = (size_of(f3) == 4) ? 0 : int'(addr % 4);
        logic [31:0] r = 32'h0;
        for (int b = 0; b < 4; b++)
            if (m[b]) r = r | (((wd >> (8 * (b - ofs))) & 32'hFF) << (8 * b));
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int ofs = int'(addr % 4);
        logic [31:0] x;
        case (f3)
            3'd0: begin x = (rd >> (8 * ofs)) & 32'hFF;   return (x >= 128)   ? x + 32'hFFFF_FF00 : x; end
            3'd4: return (rd >> (8 * ofs)) & 32'hFF;
            3'd1: begin x = (rd >> (8 * ofs)) & 32'hFFFF; return (x >= 32768) ? x + 32'hFFFF_0000 : x; end
            3'd5: return (rd >> (8 * ofs)) & 32'hFFFF;
            3'd2: return rd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic vec_t model_vec(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                                       input logic [31:0] addr, wdata, rdata, input int stall,
                                       input int block);
        logic [3:0] m = ref_mask(f3, addr);
        return mk(st, f3, rob, addr, wdata, rdata, st ? 4'h0 : m, st ? m : 4'h0,
                  st ? ref_wdata(f3, addr, wdata) : 32'h0, st ? 32'h0 : ref_load(f3, addr, rdata),
                  1'b0, stall, block);
    endfunction

    task automatic enqueue(input vec_t v);
        enq_valid = 1'b1; enq_is_store = v.st; enq_funct3 = v.f3;
        enq_pd = v.pd; enq_rd = v.rd; enq_rob = v.rob;
        @(negedge clk);
        enq_valid = 1'b0;
        mt = (mt + 1) % DEPTH;
    endtask

    task automatic agu(input int slot, input vec_t v);
        agu_valid = 1'b1; agu_idx = 3'(slot); agu_addr = v.addr; agu_wdata = v.wdata;
        @(negedge clk);
        agu_valid = 1'b0;
    endtask

    // Wait for the head request, check it, then handshake and check the writeback.
    task automatic complete_head(input vec_t v, input int exp_count);
        bit seen = 1'b0;
        logic [31:0] bm, a0;
        if (v.st) begin rob_head = v.rob; rob_head_valid = 1'b1; end
        for (int i = 0; i < 12 && !seen; i++) begin
            if (dbus.d_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk("d_req_arrives", 32'(seen), 32'd1);
        if (!seen) return;
        chk("d_addr", dbus.d_addr, v.addr & 32'hFFFF_FFFC);
        if (!v.nomask) begin
            chk("d_rmask", 32'(dbus.d_rmask), 32'(v.rmask));
            chk("d_wmask", 32'(dbus.d_wmask), 32'(v.wmask));
        end
        if (v.st) begin
            bm = {{8{v.wmask[3]}}, {8{v.wmask[2]}}, {8{v.wmask[1]}}, {8{v.wmask[0]}}};
            chk("d_wdata_lanes", dbus.d_wdata & bm, v.wexp & bm);
        end
        a0 = dbus.d_addr;
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            chk("stall_d_req", 32'(dbus.d_req), 32'd1);
            chk("stall_d_addr", dbus.d_addr, a0);
            chk("stall_no_wb", 32'(wb_valid), 32'd0);
        end
        dbus.d_ready = 1'b1;
        @(negedge clk);
        dbus.d_ready = 1'b0;
        chk("wait_d_req_low", 32'(dbus.d_req), 32'd0);
        chk("wait_no_wb", 32'(wb_valid), 32'd0);
        dbus.d_resp = 1'b1; dbus.d_rdata = v.rdata;
        @(negedge clk);
        dbus.d_resp = 1'b0; dbus.d_rdata = $urandom;
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_is_store", 32'(wb_is_store), 32'(v.st));
        chk("wb_rob", 32'(wb_rob), 32'(v.rob));
        chk("wb_rd", 32'(wb_rd), v.st ? 32'd0 : 32'(v.rd));
        if (!v.st) chk("wb_pd", 32'(wb_pd), 32'(v.pd));
        chk("wb_data", wb_data, v.dexp);
        chk("count_after_wb", 32'(count), 32'(exp_count));
        @(negedge clk);
        chk("wb_pulse_one", 32'(wb_valid), 32'd0);
        rob_head_valid = 1'b0;
    endtask

    task automatic run_access(input vec_t v);
        int slot;
        chk("enq_idx", 32'(enq_idx), 32'(mt));
        slot = mt;
        enqueue(v);
        agu(slot, v);
        if (v.st && v.block > 0) begin
            rob_head = v.rob + 5'd1; rob_head_valid = 1'b1;
            for (int i = 0; i < v.block; i++) begin
                @(negedge clk);
                chk("store_blocked", 32'(dbus.d_req), 32'd0);
            end
        end
        complete_head(v, 0);
    endtask

    task automatic rand_vec(output vec_t v);
        logic st;
        logic [2:0] f3;
        logic [31:0] addr;
        logic [2:0] lds [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st   = ($urandom_range(0, 2) == 0);
        f3   = st ? 3'($urandom_range(0, 2)) : lds[$urandom_range(0, 4)];
        addr = $urandom;
        if (size_of(f3) == 2) addr[0] = 1'b0;
        v = model_vec(st, f3, 5'($urandom), addr, $urandom, $urandom,
                      $urandom_range(0, 3), st ? $urandom_range(0, 2) : 0);
    endtask

    vec_t tbl [10];
    vec_t fq [$];
    vec_t v;
    int   slot0;
    bit   seen;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        enq_valid = 1'b0; enq_is_store = 1'b0; enq_funct3 = 3'd0; enq_pd = 6'd0;
        enq_rd = 5'd0; enq_rob = 5'd0; agu_valid = 1'b0; agu_idx = 3'd0;
        agu_addr = 32'd0; agu_wdata = 32'd0; rob_head = 5'd0; rob_head_valid = 1'b0;
        dbus.d_ready = 1'b0; dbus.d_resp = 1'b0; dbus.d_rdata = 32'd0;

        tbl[0] = mk(1'b0, 3'b010, 5'd3,  32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, 0);
        tbl[1] = mk(1'b0, 3'b000, 5'd4,  32'h0000_2003, 32'h0, 32'h80FF_FFFF, 4'h8, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0, 0, 0);
        tbl[2] = mk(1'b0, 3'b100, 5'd5,  32'h0000_2003, 32'h0, 32'h80FF_FFFF, 4'h8, 4'h0, 32'h0, 32'h0000_0080, 1'b0, 0, 0);
        tbl[3] = mk(1'b1, 3'b001, 5'd6,  32'h0000_3002, 32'h0000_1234, 32'h0, 4'h0, 4'hC, 32'h1234_0000, 32'h0, 1'b0, 0, 4);
        tbl[4] = mk(1'b0, 3'b001, 5'd7,  32'h0000_4002, 32'h0, 32'h8001_7FFF, 4'hC, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0, 0, 0);
        tbl[5] = mk(1'b0, 3'b101, 5'd8,  32'h0000_4000, 32'h0, 32'h8001_F00D, 4'h3, 4'h0, 32'h0, 32'h0000_F00D, 1'b0, 0, 0);
        tbl[6] = mk(1'b1, 3'b000, 5'd9,  32'h0000_5001, 32'h0000_00AB, 32'h0, 4'h0, 4'h2, 32'h0000_AB00, 32'h0, 1'b0, 0, 0);
        tbl[7] = mk(1'b1, 3'b010, 5'd10, 32'h0000_6008, 32'hCAFE_BABE, 32'h0, 4'h0, 4'hF, 32'hCAFE_BABE, 32'h0, 1'b0, 2, 0);
        tbl[8] = mk(1'b0, 3'b000, 5'd11, 32'h0000_7000, 32'h0, 32'h1234_567F, 4'h1, 4'h0, 32'h0, 32'h0000_007F, 1'b0, 0, 0);
        tbl[9] = mk(1'b0, 3'b011, 5'd12, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF, 4'h0, 4'h0, 32'h0, 32'h0000_0000, 1'b1, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_enq_idx", 32'(enq_idx), 32'd0);
        chk("rst_d_req", 32'(dbus.d_req), 32'd0);
        chk("rst_d_rmask", 32'(dbus.d_rmask), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_access(tbl[i]);

        // 22 random accesses bring the tail back to slot 0 before the fill sequence.
        for (int i = 0; i < 22; i++) begin
            rand_vec(v);
            run_access(v);
        end

        // Fill, overflow attempt, wrap-around enqueue, then drain in order.
        slot0 = mt;
        for (int k = 0; k < DEPTH; k++) begin
            v = model_vec(1'b0, 3'b010, 5'(k + 16), 32'h100 * k, 32'h0, $urandom, 0, 0);
            chk("fill_enq_idx", 32'(enq_idx), 32'(mt));
            enqueue(v);
            fq.push_back(v);
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        chk("full_empty", 32'(empty), 32'd0);
        v = model_vec(1'b0, 3'b010, 5'd30, 32'h0, 32'h0, 32'h0, 0, 0);
        enq_valid = 1'b1; enq_is_store = 1'b0; enq_rob = 5'd30;
        @(negedge clk);
        enq_valid = 1'b0;
        chk("overflow_count", 32'(count), 32'd8);
        chk("overflow_enq_idx", 32'(enq_idx), 32'(slot0));
        for (int k = 0; k < DEPTH; k++) agu((slot0 + k) % DEPTH, fq[k]);
        v = fq.pop_front();
        complete_head(v, DEPTH - 1);
        chk("after_one_enq_ready", 32'(enq_ready), 32'd1);
        v = model_vec(1'b0, 3'b000, 5'd31, 32'h0000_9001, 32'h0, 32'h0000_8000, 0, 0);
        chk("wrap_enq_idx", 32'(enq_idx), 32'(slot0));
        enqueue(v);
        agu(slot0, v);
        fq.push_back(v);
        chk("refill_count", 32'(count), 32'd8);
        while (fq.size() > 0) begin
            v = fq.pop_front();
            complete_head(v, fq.size());
        end
        chk("drained_empty", 32'(empty), 32'd1);

`ifdef LSU_QUEUE_FLUSH_EN
        // Flush while the head waits for its response.
        for (int k = 0; k < 3; k++) begin
            v = model_vec(1'b0, 3'b010, 5'(k + 1), 32'h40 * k, 32'h0, 32'h0, 0, 0);
            if (k == 0) slot0 = mt;
            enqueue(v);
        end
        agu(slot0, model_vec(1'b0, 3'b010, 5'd1, 32'h0, 32'h0, 32'h0, 0, 0));
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (dbus.d_req) seen = 1'b1;
            else @(negedge clk);
        end
        chk("flush_d_req_arrives", 32'(seen), 32'd1);
        dbus.d_ready = 1'b1;
        @(negedge clk);
        dbus.d_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_enq_ready", 32'(enq_ready), 32'd1);
        dbus.d_resp = 1'b1; dbus.d_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dbus.d_resp = 1'b0;
        chk("drain_no_wb", 32'(wb_valid), 32'd0);
        chk("drain_no_req", 32'(dbus.d_req), 32'd0);
        mt = 0;
        run_access(model_vec(1'b0, 3'b100, 5'd9, 32'h0000_0A02, 32'h0, 32'h00C3_0000, 0, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
